// File: rtl/host_bus_bridge_if.sv
`default_nettype none
//==============================================================================
// Module   : host_bus_bridge_if
// Purpose  : Signal bundle between the host pads / SoC transaction port and
//            host_bus_bridge. "slave" is the bridge's view, "master" is the
//            view of the surrounding logic (pads, SoC, CPU debug taps).
// Revision : 1.0 - initial release
//==============================================================================
interface host_bus_bridge_if;
  // Host register bus (pads are owned by the FPGA top level)
  logic        host_cs_i;
  logic        host_rd_n_i;
  logic        host_wr_n_i;
  logic [3:0]  host_addr_i;
  logic [15:0] host_data_i;
  logic [15:0] host_data_o;
  logic        host_data_oe_o;

  // Control register mirrors
  logic        cpu_rst_o;
  logic        soc_rst_o;
  logic        bus_master_o;
  logic        cpu_halt_o;

  // SoC transaction port
  logic [31:0] ext_tran_addr_o;
  logic [31:0] ext_tran_data_o;
  logic [1:0]  ext_tran_size_o;
  logic        ext_tran_write_o;
  logic        ext_tran_start_o;
  logic [31:0] ext_tran_data_i;
  logic        ext_tran_ready_i;

  // CPU observation
  logic [31:0] cpu_pc_i;
  logic [4:0]  cpu_state_i;

  modport slave (
    input  host_cs_i, host_rd_n_i, host_wr_n_i, host_addr_i, host_data_i,
    output host_data_o, host_data_oe_o,
    output cpu_rst_o, soc_rst_o, bus_master_o, cpu_halt_o,
    output ext_tran_addr_o, ext_tran_data_o, ext_tran_size_o,
    output ext_tran_write_o, ext_tran_start_o,
    input  ext_tran_data_i, ext_tran_ready_i,
    input  cpu_pc_i, cpu_state_i
  );

  modport master (
    output host_cs_i, host_rd_n_i, host_wr_n_i, host_addr_i, host_data_i,
    input  host_data_o, host_data_oe_o,
    input  cpu_rst_o, soc_rst_o, bus_master_o, cpu_halt_o,
    input  ext_tran_addr_o, ext_tran_data_o, ext_tran_size_o,
    input  ext_tran_write_o, ext_tran_start_o,
    output ext_tran_data_i, ext_tran_ready_i,
    output cpu_pc_i, cpu_state_i
  );
endinterface
`default_nettype wire

// File: rtl/host_bus_bridge.sv
`default_nettype none
//==============================================================================
// Module   : host_bus_bridge
// Purpose  : Host register file bridged onto the SoC transaction port. Host
//            accesses are detected from a synchronised chip-select edge;
//            single or auto-incrementing streamed transactions are issued with
//            busy/done/timeout/reject status and a completion counter.
// Revision : 1.0 - initial release
//==============================================================================
module host_bus_bridge #(
  parameter logic [15:0] SANITY_VALUE   = 16'h50FE,
  parameter int unsigned RAM_SIZE_BYTES = 65536,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  host_bus_bridge_if.slave bus
);

  localparam logic [31:0] RAM_SIZE   = 32'(RAM_SIZE_BYTES);
  localparam int          TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT_CYCLES - 1);
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  // Register word addresses
  localparam logic [3:0] REG_SANITY   = 4'd0;
  localparam logic [3:0] REG_ADDR_LO  = 4'd1;
  localparam logic [3:0] REG_ADDR_HI  = 4'd2;
  localparam logic [3:0] REG_WDATA_LO = 4'd3;
  localparam logic [3:0] REG_WDATA_HI = 4'd4;
  localparam logic [3:0] REG_CONTROL  = 4'd5;
  localparam logic [3:0] REG_RDATA_LO = 4'd6;
  localparam logic [3:0] REG_RDATA_HI = 4'd7;
  localparam logic [3:0] REG_PC_LO    = 4'd8;
  localparam logic [3:0] REG_PC_HI    = 4'd9;
  localparam logic [3:0] REG_STATUS   = 4'd10;
  localparam logic [3:0] REG_RAM_LO   = 4'd11;
  localparam logic [3:0] REG_RAM_HI   = 4'd12;
  localparam logic [3:0] REG_TXN      = 4'd13;

  // start (bit 3) and clr_err (bit 9) are action bits and never stored
  localparam logic [15:0] CTRL_STORE_MASK = 16'hFDF7;
  localparam logic [15:0] CTRL_RESET      = 16'h0103;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t state_q, state_nx;

  logic        cs_s1, cs_s2, cs_s3;
  logic        access, rd_acc, wr_acc;
  logic [31:0] addr_q, addr_nx;
  logic [31:0] wdata_q, wdata_nx;
  logic [15:0] ctrl_q, ctrl_nx;
  logic [31:0] rdata_q;
  logic        done_q, tout_err_q, rej_err_q;
  logic [15:0] txn_q;
  logic [15:0] host_rdata_q;
  logic [15:0] rd_mux;
  logic [31:0] tran_addr_q, tran_data_q;
  logic [1:0]  tran_size_q;
  logic        tran_write_q, tran_stream_q;
  logic [TW-1:0] tcnt_q;
  logic [31:0] incr;
  logic        trigger, accept, reject, busy, complete, timeout, start_c;

  assign access = cs_s2 & ~cs_s3;
  assign rd_acc = access & ~bus.host_rd_n_i;
  assign wr_acc = access & ~bus.host_wr_n_i;

  assign busy     = (state_q != ST_IDLE);
  assign complete = (state_q == ST_WAIT) && bus.ext_tran_ready_i;
  assign timeout  = (state_q == ST_WAIT) && !bus.ext_tran_ready_i &&
                    TIMEOUT_EN && (tcnt_q == TMAX);

  // Triggers see the control fields as they will be after this access's write
  assign trigger = (wr_acc && bus.host_addr_i == REG_CONTROL && bus.host_data_i[3]) ||
                   (wr_acc && bus.host_addr_i == REG_WDATA_HI && ctrl_nx[5] && ctrl_nx[4]) ||
                   (rd_acc && bus.host_addr_i == REG_RDATA_HI && ctrl_nx[5] && !ctrl_nx[4]);
  assign accept  = trigger && !busy;
  assign reject  = trigger && busy;

  // Chip-select synchroniser; access fires on the synchronised rising edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cs_s1 <= 1'b0;
      cs_s2 <= 1'b0;
      cs_s3 <= 1'b0;
    end else begin
      cs_s1 <= bus.host_cs_i;
      cs_s2 <= cs_s1;
      cs_s3 <= cs_s2;
    end
  end

  // Stream address step: size 3 is treated as a word
  always_comb begin
    case (tran_size_q)
      2'd0:    incr = 32'd1;
      2'd1:    incr = 32'd2;
      default: incr = 32'd4;
    endcase
  end

  // Next values of the RW registers; a host ADDR write overrides the increment
  always_comb begin
    addr_nx  = addr_q;
    wdata_nx = wdata_q;
    ctrl_nx  = ctrl_q;
    if (complete && tran_stream_q) addr_nx = tran_addr_q + incr;
    if (wr_acc) begin
      case (bus.host_addr_i)
        REG_ADDR_LO:  addr_nx[15:0]   = bus.host_data_i;
        REG_ADDR_HI:  addr_nx[31:16]  = bus.host_data_i;
        REG_WDATA_LO: wdata_nx[15:0]  = bus.host_data_i;
        REG_WDATA_HI: wdata_nx[31:16] = bus.host_data_i;
        REG_CONTROL:  ctrl_nx         = bus.host_data_i & CTRL_STORE_MASK;
        default:      ;
      endcase
    end
  end

  // Host read mux, sampled with pre-write register values
  always_comb begin
    rd_mux = 16'h0000;
    case (bus.host_addr_i)
      REG_SANITY:   rd_mux = SANITY_VALUE;
      REG_ADDR_LO:  rd_mux = addr_q[15:0];
      REG_ADDR_HI:  rd_mux = addr_q[31:16];
      REG_WDATA_LO: rd_mux = wdata_q[15:0];
      REG_WDATA_HI: rd_mux = wdata_q[31:16];
      REG_CONTROL:  rd_mux = ctrl_q;
      REG_RDATA_LO: rd_mux = rdata_q[15:0];
      REG_RDATA_HI: rd_mux = rdata_q[31:16];
      REG_PC_LO:    rd_mux = bus.cpu_pc_i[15:0];
      REG_PC_HI:    rd_mux = bus.cpu_pc_i[31:16];
      REG_STATUS:   rd_mux = {3'b000, bus.cpu_state_i, 4'b0000,
                              rej_err_q, tout_err_q, done_q, busy};
      REG_RAM_LO:   rd_mux = RAM_SIZE[15:0];
      REG_RAM_HI:   rd_mux = RAM_SIZE[31:16];
      REG_TXN:      rd_mux = txn_q;
      default:      rd_mux = 16'h0000;
    endcase
  end

  // Register file and host read data holding register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      ctrl_q       <= CTRL_RESET;
      host_rdata_q <= 16'h0;
    end else begin
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
      ctrl_q  <= ctrl_nx;
      if (rd_acc) host_rdata_q <= rd_mux;
    end
  end

  // Transaction state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_nx;
  end

  // Transaction next state and start pulse
  always_comb begin
    state_nx = state_q;
    start_c  = 1'b0;
    case (state_q)
      ST_IDLE:  if (trigger) state_nx = ST_ISSUE;
      ST_ISSUE: begin
        start_c  = 1'b1;
        state_nx = ST_WAIT;
      end
      ST_WAIT:  if (complete || timeout) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Capture the transaction on acceptance so it is valid alongside start
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tran_addr_q   <= 32'h0;
      tran_data_q   <= 32'h0;
      tran_size_q   <= 2'd0;
      tran_write_q  <= 1'b0;
      tran_stream_q <= 1'b0;
    end else if (accept) begin
      tran_addr_q   <= addr_nx;
      tran_data_q   <= wdata_nx;
      tran_size_q   <= ctrl_nx[7:6];
      tran_write_q  <= ctrl_nx[4];
      tran_stream_q <= ctrl_nx[5];
    end
  end

  // WAIT-cycle counter for the timeout
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != ST_WAIT) tcnt_q <= '0;
    else                             tcnt_q <= tcnt_q + TW'(1);
  end

  // Status flags, read data capture and completion counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_q     <= 1'b0;
      tout_err_q <= 1'b0;
      rej_err_q  <= 1'b0;
      rdata_q    <= 32'h0;
      txn_q      <= 16'h0;
    end else begin
      if (accept)        done_q <= 1'b0;
      else if (complete) done_q <= 1'b1;
      if (wr_acc && bus.host_addr_i == REG_CONTROL && bus.host_data_i[9]) begin
        tout_err_q <= 1'b0;
        rej_err_q  <= 1'b0;
      end
      if (timeout) tout_err_q <= 1'b1;
      if (reject)  rej_err_q  <= 1'b1;
      if (complete) begin
        txn_q <= txn_q + 16'd1;
        if (!tran_write_q) rdata_q <= bus.ext_tran_data_i;
      end
    end
  end

  assign bus.host_data_o      = host_rdata_q;
  assign bus.host_data_oe_o   = ~bus.host_rd_n_i;
  assign bus.cpu_rst_o        = ctrl_q[0];
  assign bus.soc_rst_o        = ctrl_q[1];
  assign bus.bus_master_o     = ctrl_q[2];
  assign bus.cpu_halt_o       = ctrl_q[8];
  assign bus.ext_tran_addr_o  = tran_addr_q;
  assign bus.ext_tran_data_o  = tran_data_q;
  assign bus.ext_tran_size_o  = tran_size_q;
  assign bus.ext_tran_write_o = tran_write_q;
  assign bus.ext_tran_start_o = start_c;

endmodule
`default_nettype wire

// File: tb/tb_host_bus_bridge.sv
`default_nettype none
//==============================================================================
// Module   : tb_host_bus_bridge
// Purpose  : Directed self-checking bench for host_bus_bridge with a simple
//            SoC responder and start-pulse recorder.
// Revision : 1.0 - initial release
//==============================================================================
module tb_host_bus_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  host_bus_bridge_if bus ();

  host_bus_bridge #(
    .SANITY_VALUE  (16'h50FE),
    .RAM_SIZE_BYTES(65536),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Start-pulse recorder
  int          start_cnt = 0;
  logic [31:0] st_addr  [0:63];
  logic [31:0] st_data  [0:63];
  logic [1:0]  st_size  [0:63];
  logic        st_write [0:63];

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bus.ext_tran_start_o === 1'b1) begin
        if (start_cnt < 64) begin
          st_addr[start_cnt]  = bus.ext_tran_addr_o;
          st_data[start_cnt]  = bus.ext_tran_data_o;
          st_size[start_cnt]  = bus.ext_tran_size_o;
          st_write[start_cnt] = bus.ext_tran_write_o;
        end
        start_cnt++;
      end
    end
  end

  // SoC responder: ready resp_delay cycles after start; never if resp_delay <= 0
  int          resp_delay = 3;
  logic [31:0] resp_q[$];

  initial begin
    bus.ext_tran_ready_i = 1'b0;
    bus.ext_tran_data_i  = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (bus.ext_tran_start_o === 1'b1 && resp_delay > 0) begin
        repeat (resp_delay) @(posedge clk);
        #1;
        bus.ext_tran_data_i  = (resp_q.size() > 0) ? resp_q.pop_front() : 32'hA5A5_A5A5;
        bus.ext_tran_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.ext_tran_ready_i = 1'b0;
      end
    end
  end

  // One host access; called 1ns after a clock edge X, access edge is X+3,
  // returns 1ns after X+3 with host_data_o updated.
  task automatic host_access(input logic rd, input logic wr,
                             input logic [3:0] a, input logic [15:0] d);
    bus.host_addr_i = a;
    bus.host_data_i = d;
    bus.host_rd_n_i = ~rd;
    bus.host_wr_n_i = ~wr;
    bus.host_cs_i   = 1'b1;
    @(posedge clk); #1;
    bus.host_cs_i   = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.host_rd_n_i = 1'b1;
    bus.host_wr_n_i = 1'b1;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [15:0] d);
    host_access(1'b0, 1'b1, a, d);
  endtask

  task automatic host_read(input logic [3:0] a, output logic [15:0] d);
    host_access(1'b1, 1'b0, a, 16'h0000);
    d = bus.host_data_o;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    tests_run++; if (bus.host_data_o !== 16'h0000) begin tests_failed++; $display("FAIL rst_host_data: got %h want %h", bus.host_data_o, 16'h0000); end
    tests_run++; if (bus.ext_tran_addr_o !== 32'h0) begin tests_failed++; $display("FAIL rst_tran_addr: got %h want %h", bus.ext_tran_addr_o, 32'h0); end
    tests_run++; if (bus.ext_tran_start_o !== 1'b0) begin tests_failed++; $display("FAIL rst_start: got %b want 0", bus.ext_tran_start_o); end
    tests_run++; if ({bus.cpu_halt_o, bus.bus_master_o, bus.soc_rst_o, bus.cpu_rst_o} !== 4'b1011) begin tests_failed++; $display("FAIL rst_mirrors: got %b want 1011", {bus.cpu_halt_o, bus.bus_master_o, bus.soc_rst_o, bus.cpu_rst_o}); end
    bus.host_rd_n_i = 1'b0; #1;
    tests_run++; if (bus.host_data_oe_o !== 1'b1) begin tests_failed++; $display("FAIL oe_on: got %b want 1", bus.host_data_oe_o); end
    bus.host_rd_n_i = 1'b1; #1;
    tests_run++; if (bus.host_data_oe_o !== 1'b0) begin tests_failed++; $display("FAIL oe_off: got %b want 0", bus.host_data_oe_o); end
    @(posedge clk); #1;
    host_read(4'd0, v);  tests_run++; if (v !== 16'h50FE) begin tests_failed++; $display("FAIL sanity: got %h want %h", v, 16'h50FE); end
    host_read(4'd5, v);  tests_run++; if (v !== 16'h0103) begin tests_failed++; $display("FAIL rst_control: got %h want %h", v, 16'h0103); end
    host_read(4'd11, v); tests_run++; if (v !== 16'h0000) begin tests_failed++; $display("FAIL ram_lo: got %h want %h", v, 16'h0000); end
    host_read(4'd12, v); tests_run++; if (v !== 16'h0001) begin tests_failed++; $display("FAIL ram_hi: got %h want %h", v, 16'h0001); end
    host_read(4'd10, v); tests_run++; if (v !== 16'h1500) begin tests_failed++; $display("FAIL rst_status: got %h want %h", v, 16'h1500); end
    host_read(4'd8, v);  tests_run++; if (v !== 16'h5678) begin tests_failed++; $display("FAIL pc_lo: got %h want %h", v, 16'h5678); end
    host_read(4'd9, v);  tests_run++; if (v !== 16'h1234) begin tests_failed++; $display("FAIL pc_hi: got %h want %h", v, 16'h1234); end
    host_read(4'd13, v); tests_run++; if (v !== 16'h0000) begin tests_failed++; $display("FAIL rst_txn: got %h want %h", v, 16'h0000); end
  endtask

  task automatic test_registers();
    logic [15:0] v;
    host_write(4'd0, 16'h1111);
    host_read(4'd0, v);  tests_run++; if (v !== 16'h50FE) begin tests_failed++; $display("FAIL ro_write_ignored: got %h want %h", v, 16'h50FE); end
    host_access(1'b1, 1'b1, 4'd1, 16'hAAAA);
    tests_run++; if (bus.host_data_o !== 16'h0000) begin tests_failed++; $display("FAIL rw_same_access_old: got %h want %h", bus.host_data_o, 16'h0000); end
    host_read(4'd1, v);  tests_run++; if (v !== 16'hAAAA) begin tests_failed++; $display("FAIL rw_same_access_new: got %h want %h", v, 16'hAAAA); end
    host_write(4'd14, 16'h5555);
    host_read(4'd14, v); tests_run++; if (v !== 16'h0000) begin tests_failed++; $display("FAIL reg14: got %h want %h", v, 16'h0000); end
    host_write(4'd5, 16'hFE07);
    host_read(4'd5, v);  tests_run++; if (v !== 16'hFC07) begin tests_failed++; $display("FAIL control_rw: got %h want %h", v, 16'hFC07); end
    tests_run++; if ({bus.cpu_halt_o, bus.bus_master_o, bus.soc_rst_o, bus.cpu_rst_o} !== 4'b0111) begin tests_failed++; $display("FAIL ctrl_mirrors: got %b want 0111", {bus.cpu_halt_o, bus.bus_master_o, bus.soc_rst_o, bus.cpu_rst_o}); end
  endtask

  task automatic test_single_write();
    logic [15:0] v;
    int n0;
    resp_delay = 5;
    host_write(4'd1, 16'h1000);
    host_write(4'd2, 16'h0000);
    host_write(4'd3, 16'hBEEF);
    host_write(4'd4, 16'hDEAD);
    n0 = start_cnt;
    host_write(4'd5, 16'h0098);
    tests_run++; if (bus.ext_tran_start_o !== 1'b1) begin tests_failed++; $display("FAIL start_latency: got %b want 1", bus.ext_tran_start_o); end
    tests_run++; if (bus.ext_tran_addr_o !== 32'h0000_1000) begin tests_failed++; $display("FAIL wr_addr: got %h want %h", bus.ext_tran_addr_o, 32'h0000_1000); end
    tests_run++; if (bus.ext_tran_data_o !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL wr_data: got %h want %h", bus.ext_tran_data_o, 32'hDEAD_BEEF); end
    tests_run++; if ({bus.ext_tran_write_o, bus.ext_tran_size_o} !== 3'b110) begin tests_failed++; $display("FAIL wr_write_size: got %b want 110", {bus.ext_tran_write_o, bus.ext_tran_size_o}); end
    @(posedge clk); #1;
    tests_run++; if (bus.ext_tran_start_o !== 1'b0) begin tests_failed++; $display("FAIL start_width: got %b want 0", bus.ext_tran_start_o); end
    repeat (8) @(posedge clk); #1;
    tests_run++; if (start_cnt !== n0 + 1) begin tests_failed++; $display("FAIL wr_start_count: got %0d want %0d", start_cnt, n0 + 1); end
    tests_run++; if (bus.ext_tran_addr_o !== 32'h0000_1000) begin tests_failed++; $display("FAIL wr_addr_stable: got %h want %h", bus.ext_tran_addr_o, 32'h0000_1000); end
    host_read(4'd10, v); tests_run++; if (v !== 16'h1502) begin tests_failed++; $display("FAIL wr_status_done: got %h want %h", v, 16'h1502); end
    host_read(4'd13, v); tests_run++; if (v !== 16'h0001) begin tests_failed++; $display("FAIL wr_txn: got %h want %h", v, 16'h0001); end
    host_read(4'd5, v);  tests_run++; if (v !== 16'h0090) begin tests_failed++; $display("FAIL wr_control: got %h want %h", v, 16'h0090); end
  endtask

  task automatic test_stream_read();
    logic [15:0] v;
    int n0;
    resp_delay = 3;
    host_write(4'd1, 16'hFFFE);
    host_write(4'd2, 16'h0000);
    resp_q.push_back(32'h0011_0011);
    resp_q.push_back(32'h0022_0022);
    resp_q.push_back(32'h0033_0033);
    resp_q.push_back(32'h0044_0044);
    n0 = start_cnt;
    host_write(4'd5, 16'h0068);
    repeat (8) @(posedge clk); #1;
    tests_run++; if ({st_write[n0], st_size[n0], st_addr[n0]} !== {1'b0, 2'd1, 32'h0000_FFFE}) begin tests_failed++; $display("FAIL stream_first: got %b %0d %h want 0 1 0000fffe", st_write[n0], st_size[n0], st_addr[n0]); end
    host_read(4'd7, v); tests_run++; if (v !== 16'h0011) begin tests_failed++; $display("FAIL stream_data0: got %h want %h", v, 16'h0011); end
    repeat (8) @(posedge clk); #1;
    tests_run++; if (st_addr[n0 + 1] !== 32'h0001_0000) begin tests_failed++; $display("FAIL stream_addr1: got %h want %h", st_addr[n0 + 1], 32'h0001_0000); end
    host_read(4'd7, v); tests_run++; if (v !== 16'h0022) begin tests_failed++; $display("FAIL stream_data1: got %h want %h", v, 16'h0022); end
    repeat (8) @(posedge clk); #1;
    tests_run++; if (st_addr[n0 + 2] !== 32'h0001_0002) begin tests_failed++; $display("FAIL stream_addr2: got %h want %h", st_addr[n0 + 2], 32'h0001_0002); end
    host_read(4'd7, v); tests_run++; if (v !== 16'h0033) begin tests_failed++; $display("FAIL stream_data2: got %h want %h", v, 16'h0033); end
    repeat (8) @(posedge clk); #1;
    tests_run++; if (start_cnt !== n0 + 4) begin tests_failed++; $display("FAIL stream_starts: got %0d want %0d", start_cnt, n0 + 4); end
    host_read(4'd2, v);  tests_run++; if (v !== 16'h0001) begin tests_failed++; $display("FAIL stream_addr_hi: got %h want %h", v, 16'h0001); end
    host_read(4'd1, v);  tests_run++; if (v !== 16'h0006) begin tests_failed++; $display("FAIL stream_addr_lo: got %h want %h", v, 16'h0006); end
    host_read(4'd6, v);  tests_run++; if (v !== 16'h0044) begin tests_failed++; $display("FAIL stream_prefetch: got %h want %h", v, 16'h0044); end
    host_read(4'd13, v); tests_run++; if (v !== 16'h0005) begin tests_failed++; $display("FAIL stream_txn: got %h want %h", v, 16'h0005); end
  endtask

  task automatic test_reject();
    logic [15:0] v;
    int n0;
    resp_delay = 8;
    n0 = start_cnt;
    host_write(4'd5, 16'h0098);
    host_write(4'd5, 16'h0098);
    repeat (12) @(posedge clk); #1;
    tests_run++; if (start_cnt !== n0 + 1) begin tests_failed++; $display("FAIL reject_no_start: got %0d want %0d", start_cnt, n0 + 1); end
    host_read(4'd10, v); tests_run++; if (v !== 16'h150A) begin tests_failed++; $display("FAIL reject_status: got %h want %h", v, 16'h150A); end
    host_read(4'd13, v); tests_run++; if (v !== 16'h0006) begin tests_failed++; $display("FAIL reject_txn: got %h want %h", v, 16'h0006); end
    host_write(4'd5, 16'h0200);
    host_read(4'd10, v); tests_run++; if (v !== 16'h1502) begin tests_failed++; $display("FAIL clr_err: got %h want %h", v, 16'h1502); end
  endtask

  task automatic test_timeout();
    logic [15:0] v;
    int n0;
    resp_delay = 0;
    n0 = start_cnt;
    // Status sampled just before the 16th WAIT edge: still busy
    host_write(4'd5, 16'h0098);
    repeat (14) @(posedge clk); #1;
    host_read(4'd10, v); tests_run++; if (v !== 16'h1501) begin tests_failed++; $display("FAIL timeout_before: got %h want %h", v, 16'h1501); end
    repeat (4) @(posedge clk); #1;
    host_write(4'd5, 16'h0200);
    // Status sampled one cycle after the 16th WAIT edge: timed out
    host_write(4'd5, 16'h0098);
    repeat (15) @(posedge clk); #1;
    host_read(4'd10, v); tests_run++; if (v !== 16'h1504) begin tests_failed++; $display("FAIL timeout_after: got %h want %h", v, 16'h1504); end
    host_read(4'd13, v); tests_run++; if (v !== 16'h0006) begin tests_failed++; $display("FAIL timeout_txn: got %h want %h", v, 16'h0006); end
    bus.ext_tran_data_i  = 32'hCAFE_F00D;
    bus.ext_tran_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.ext_tran_ready_i = 1'b0;
    host_read(4'd6, v);  tests_run++; if (v !== 16'h0044) begin tests_failed++; $display("FAIL late_ready_rdata: got %h want %h", v, 16'h0044); end
    host_read(4'd13, v); tests_run++; if (v !== 16'h0006) begin tests_failed++; $display("FAIL late_ready_txn: got %h want %h", v, 16'h0006); end
    host_read(4'd10, v); tests_run++; if (v !== 16'h1504) begin tests_failed++; $display("FAIL late_ready_status: got %h want %h", v, 16'h1504); end
    tests_run++; if (start_cnt !== n0 + 2) begin tests_failed++; $display("FAIL timeout_starts: got %0d want %0d", start_cnt, n0 + 2); end
  endtask

  task automatic test_reset_in_wait();
    logic [15:0] v;
    int n0;
    resp_delay = 6;
    n0 = start_cnt;
    host_write(4'd5, 16'h0098);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (bus.ext_tran_start_o !== 1'b0) begin tests_failed++; $display("FAIL rstw_start: got %b want 0", bus.ext_tran_start_o); end
    tests_run++; if ({bus.ext_tran_write_o, bus.ext_tran_addr_o} !== 33'h0) begin tests_failed++; $display("FAIL rstw_tran: got %b %h want 0 00000000", bus.ext_tran_write_o, bus.ext_tran_addr_o); end
    rst = 1'b0;
    repeat (12) @(posedge clk); #1;
    tests_run++; if (start_cnt !== n0 + 1) begin tests_failed++; $display("FAIL rstw_starts: got %0d want %0d", start_cnt, n0 + 1); end
    host_read(4'd5, v);  tests_run++; if (v !== 16'h0103) begin tests_failed++; $display("FAIL rstw_control: got %h want %h", v, 16'h0103); end
    host_read(4'd10, v); tests_run++; if (v !== 16'h1500) begin tests_failed++; $display("FAIL rstw_status: got %h want %h", v, 16'h1500); end
    host_read(4'd13, v); tests_run++; if (v !== 16'h0000) begin tests_failed++; $display("FAIL rstw_txn: got %h want %h", v, 16'h0000); end
    host_read(4'd6, v);  tests_run++; if (v !== 16'h0000) begin tests_failed++; $display("FAIL rstw_rdata: got %h want %h", v, 16'h0000); end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    bus.host_cs_i   = 1'b0;
    bus.host_rd_n_i = 1'b1;
    bus.host_wr_n_i = 1'b1;
    bus.host_addr_i = 4'd0;
    bus.host_data_i = 16'h0;
    bus.cpu_pc_i    = 32'h1234_5678;
    bus.cpu_state_i = 5'h15;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_registers();
    test_single_write();
    test_stream_read();
    test_reject();
    test_timeout();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/host_bus_bridge.md
Name: host_bus_bridge

Overview:
- Successor host-to-SoC bridge. Exposes a register file to the external asynchronous host bus (chip select, read and write strobes).
- Issues single or auto-incrementing streamed SoC bus transactions, with busy/timeout/rejection status and a transaction counter.
- Sits between the FPGA top level, which owns the tristate pads, and the soc transaction port.

Parameters:
SANITY_VALUE, 16'h50FE, value returned by register 0
RAM_SIZE_BYTES, 65536, value returned by the RAM_LO and RAM_HI registers
TIMEOUT_CYCLES, 1024, WAIT-state cycles before abort; 0 disables the timeout

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; synchronous, active-high
host_cs_i  in  1  combined host chip select, asynchronous, active-high
host_rd_n_i  in  1  host read strobe, active-low
host_wr_n_i  in  1  host write strobe, active-low
host_addr_i  in  4  host register word address
host_data_i  in  16  host write data
host_data_o  out  16  host read data
host_data_oe_o  out  1  pad drive enable, = ~host_rd_n_i (combinational)
cpu_rst_o, soc_rst_o, bus_master_o, cpu_halt_o  out  1 each  mirrors of CONTROL bits
ext_tran_addr_o  out  32  transaction address
ext_tran_data_o  out  32  transaction write data
ext_tran_size_o  out  2  0 = byte, 1 = half, 2 = word
ext_tran_write_o  out  1  1 = write
ext_tran_start_o  out  1  one-cycle start pulse
ext_tran_data_i  in  32  read data, valid while ready is high
ext_tran_ready_i  in  1  transaction complete
cpu_pc_i  in  32  CPU PC
cpu_state_i  in  5  CPU state

Behaviour:

Host access detection:
- host_cs_i passes through a 3-flop synchroniser s1 -> s2 -> s3.
- access = s2 & ~s3, one cycle per CS rising edge.
- On access, sample host_rd_n_i, host_wr_n_i, host_addr_i and host_data_i (host holds them stable).
- Read (rd_n = 0): host_data_o <= mux(addr), held until the next read access.
- Write (wr_n = 0): update the register.
- Both strobes low: the read returns the pre-write value, and the write also takes effect.

Register map (16-bit registers):
- 0 SANITY (RO).
- 1 ADDR_LO, 2 ADDR_HI (RW).
- 3 WDATA_LO, 4 WDATA_HI (RW).
- 5 CONTROL (RW):
  - [0] cpu_rst, [1] soc_rst, [2] bus_master
  - [3] start: write 1 triggers; reads 0
  - [4] we, [5] stream_en, [7:6] size, [8] cpu_halt
  - [9] clr_err: write 1 clears both sticky errors; reads 0
  - [15:10] RW scratch
- 6 RDATA_LO, 7 RDATA_HI (RO).
- 8 PC_LO, 9 PC_HI (RO).
- 10 STATUS (RO): [0] busy, [1] done (set on completion, cleared on the next trigger), [2] timeout_err (sticky), [3] reject_err (sticky), [12:8] cpu_state_i, other bits 0.
- 11 RAM_LO, 12 RAM_HI (RO).
- 13 TXN_COUNT (RO): successful completions, wraps at 16 bits.
- 14, 15: read 0, writes ignored. Writes to all RO registers are ignored.

Triggers (evaluated on the access cycle):
- Write CONTROL with bit3 = 1.
- Write WDATA_HI while stream_en = 1 and we = 1.
- Read RDATA_HI while stream_en = 1 and we = 0; the host receives the current data and the next read is prefetched.
- The fields a trigger uses (we, size, stream_en) are the post-write values.

Transaction FSM:
- IDLE: on trigger go to ISSUE and clear done.
- ISSUE (1 cycle):
  - latch ext_tran_addr_o/data_o/size_o/write_o from the registers;
  - ext_tran_start_o = 1;
  - go to WAIT.
- WAIT, first cycle with ext_tran_ready_i = 1:
  - on a read, RDATA <= ext_tran_data_i;
  - done = 1, TXN_COUNT += 1;
  - if stream_en, ADDR <= latched addr + (1 << size), with size 3 treated as 4 bytes, wrapping modulo 2^32;
  - go to IDLE.
- WAIT timeout: if TIMEOUT_CYCLES != 0 and TIMEOUT_CYCLES cycles pass with no ready:
  - timeout_err = 1, RDATA unchanged, no increment, done stays 0;
  - go to IDLE.
- busy = 1 in ISSUE and WAIT.
- Trigger while busy: ignored (not queued) and reject_err = 1.

Output stability and latency:
- ext_tran_* outputs other than start stay stable between ISSUE cycles. A host write to ADDR or WDATA during WAIT does not affect the in-flight transaction.
- If the auto-increment and a host ADDR write occur in the same cycle, the host write wins. An earlier host write during WAIT is overwritten by the increment.
- Latency: CS rising edge sampled at clock edge t -> access at t+2 -> start pulse at t+3.
- A ready seen in the ISSUE cycle is ignored.

Reset (rst_i = 1):
- cpu_rst = 1, soc_rst = 1, cpu_halt = 1.
- All other registers, host_data_o, ext_tran_* outputs, counters and status: 0.
- Synchroniser flops: 0. FSM: IDLE.
- Reset mid-transaction abandons it: start is low, and a late ready is ignored because the FSM is in IDLE.

Test Plan:
- Reset, then host read address 0 -> 16'h50FE. Read CONTROL -> 16'h0103. Read RAM_LO/RAM_HI -> 16'h0000 / 16'h0001.
- Set ADDR = 0x0000_1000, WDATA = 0xDEADBEEF, CONTROL = we | start | size 2. Expect:
  - ext_tran_start_o high for exactly 1 cycle, 3 clocks after the CS edge;
  - ext_tran_addr_o = 0x1000, ext_tran_data_o = 0xDEADBEEF, ext_tran_write_o = 1;
  - ready after 5 cycles -> STATUS done = 1, TXN_COUNT = 1.
- Stream read, size 1, start address 0x0000_FFFE, three RDATA_HI reads, SoC returning 0x11 / 0x22 / 0x33. Expect:
  - addresses 0xFFFE, 0x10000, 0x10002 (carry into ADDR_HI);
  - host sees each value one RDATA_HI read after issue.
- Trigger a start while WAIT is pending -> reject_err = 1, no second start pulse. Write CONTROL bit9 -> STATUS[3:2] = 0.
- Run with TIMEOUT_CYCLES = 16 and ready never asserted:
  - at WAIT cycle 16, timeout_err = 1, busy = 0, TXN_COUNT unchanged;
  - a ready asserted afterwards is ignored.
- Assert rst_i during WAIT -> next cycle FSM IDLE, CONTROL = 0x0103, ext_tran_start_o = 0; a subsequent ready changes nothing.
